// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state, lamp encoding and default dwell constants for the intersection
package traffic_pkg;
  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2, PED_WALK, FLASH
  } state_e;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_DARK   = 3'b000;
  localparam int GREEN_CYC_DEF  = 8;
  localparam int YELLOW_CYC_DEF = 3;
  localparam int ALLRED_CYC_DEF = 2;
  localparam int WALK_CYC_DEF   = 6;
  localparam int FLASH_CYC_DEF  = 4;
  localparam int CNT_W_DEF      = 8;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter that parks at zero and flags it
module dwell_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  always_comb cnt_d = load_i ? val_i : (zero_o ? cnt_q : cnt_q - CNT_W'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection: two-road signal controller with pedestrian walk and flashing-yellow mode
module traffic_intersection
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = GREEN_CYC_DEF,
  parameter int YELLOW_CYC = YELLOW_CYC_DEF,
  parameter int ALLRED_CYC = ALLRED_CYC_DEF,
  parameter int WALK_CYC   = WALK_CYC_DEF,
  parameter int FLASH_CYC  = FLASH_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] LD_FLASH  = CNT_W'(FLASH_CYC - 1);
  state_e state_q, state_d;
  logic pend_q, pend_d, flash_q, flash_d, ack_q, ack_d, load, zero;
  logic [CNT_W-1:0] load_val;
  dwell_timer #(.CNT_W(CNT_W), .RST_VAL(LD_ALLRED)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .val_i  (load_val),
    .zero_o (zero)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (zero) state_d = NS_YELLOW;
      NS_YELLOW: if (zero) state_d = ALL_RED_1;
      ALL_RED_1: if (zero) state_d = flash_en ? FLASH : EW_GREEN;
      EW_GREEN:  if (zero) state_d = EW_YELLOW;
      EW_YELLOW: if (zero) state_d = ALL_RED_2;
      ALL_RED_2: if (zero) state_d = flash_en ? FLASH : (pend_q || ped_req) ? PED_WALK : NS_GREEN;
      PED_WALK:  if (zero) state_d = flash_en ? FLASH : NS_GREEN;
      default:   state_d = flash_en ? FLASH : ALL_RED_2;
    endcase
  end
  // FLASH reuses the dwell timer as its blink half-period
  always_comb begin
    load     = (state_d != state_q) || (state_q == FLASH && zero);
    load_val = (state_d == NS_GREEN || state_d == EW_GREEN) ? LD_GREEN :
               (state_d == NS_YELLOW || state_d == EW_YELLOW) ? LD_YELLOW :
               state_d == PED_WALK ? LD_WALK :
               state_d == FLASH ? LD_FLASH : LD_ALLRED;
    ack_d    = state_d == PED_WALK && state_q != PED_WALK;
    pend_d   = ack_d ? 1'b0 : pend_q | (ped_req && state_q != PED_WALK);
    flash_d  = state_q == FLASH ? flash_q ^ zero : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ALL_RED_2;
      pend_q  <= 1'b0;
      flash_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      flash_q <= flash_d;
      ack_q   <= ack_d;
    end
  assign ns_light = state_q == FLASH ? (flash_q ? LAMP_DARK : LAMP_YELLOW) :
                    state_q == NS_GREEN ? LAMP_GREEN :
                    state_q == NS_YELLOW ? LAMP_YELLOW : LAMP_RED;
  assign ew_light = state_q == FLASH ? (flash_q ? LAMP_DARK : LAMP_YELLOW) :
                    state_q == EW_GREEN ? LAMP_GREEN :
                    state_q == EW_YELLOW ? LAMP_YELLOW : LAMP_RED;
  assign ped_walk = state_q == PED_WALK;
  assign ped_ack  = ack_q;
  assign phase    = state_q;
endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: scenario and random checks against a phase/elapsed-time model
module tb_traffic_intersection;
  import traffic_pkg::*;
  localparam int G = 8, Y = 3, AR = 2, W = 6, FC = 4;
  logic clk = 1'b0, rst_n = 1'b1, ped_req = 1'b0, flash_en = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic ped_walk, ped_ack;
  int asserts = 0, fails = 0;
  bit started = 0;
  state_e m_ph;
  int m_el;
  bit m_pend;
  traffic_intersection dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ped_req  (ped_req),
    .flash_en (flash_en),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .ped_walk (ped_walk),
    .ped_ack  (ped_ack),
    .phase    (phase)
  );
  always #5 clk = ~clk;
  wire [10:0] obs = {ns_light, ew_light, ped_walk, ped_ack, phase};
  function automatic int dur(state_e s);
    if (s inside {NS_GREEN, EW_GREEN}) return G;
    if (s inside {NS_YELLOW, EW_YELLOW}) return Y;
    if (s == PED_WALK) return W;
    return AR;
  endfunction
  function automatic logic [10:0] exp_out();
    logic [2:0] n, e;
    if (m_ph == FLASH) begin
      n = ((m_el / FC) % 2) ? 3'b000 : 3'b001;
      e = n;
    end else begin
      n = m_ph == NS_GREEN ? 3'b010 : m_ph == NS_YELLOW ? 3'b001 : 3'b100;
      e = m_ph == EW_GREEN ? 3'b010 : m_ph == EW_YELLOW ? 3'b001 : 3'b100;
    end
    return {n, e, m_ph == PED_WALK, m_ph == PED_WALK && m_el == 0, 3'(m_ph)};
  endfunction
  task automatic model_reset();
    m_ph = ALL_RED_2; m_el = 0; m_pend = 0;
  endtask
  task automatic model_step(input bit r, input bit f);
    state_e nx = m_ph;
    if (m_ph == FLASH) nx = f ? FLASH : ALL_RED_2;
    else if (m_el + 1 >= dur(m_ph))
      case (m_ph)
        NS_GREEN:  nx = NS_YELLOW;
        NS_YELLOW: nx = ALL_RED_1;
        ALL_RED_1: nx = f ? FLASH : EW_GREEN;
        EW_GREEN:  nx = EW_YELLOW;
        EW_YELLOW: nx = ALL_RED_2;
        ALL_RED_2: nx = f ? FLASH : (m_pend || r) ? PED_WALK : NS_GREEN;
        default:   nx = f ? FLASH : NS_GREEN;
      endcase
    if (m_ph != PED_WALK) m_pend = (m_pend || r) && nx != PED_WALK;
    m_el = (nx == m_ph) ? m_el + 1 : 0;
    m_ph = nx;
  endtask
  task automatic tick(input bit r, input bit f);
    ped_req = r; flash_en = f;
    @(posedge clk);
    model_step(r, f);
    #1;
  endtask
  task automatic advance_to(input state_e s, input int el, input bit f, output bit ok);
    ok = (m_ph == s && m_el == el);
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(0, f);
      ok = (m_ph == s && m_el == el);
    end
  endtask
  // safety: both directions never released at once outside FLASH
  always @(negedge clk)
    if (started && phase !== 3'(FLASH)) begin
      asserts++;
      if (ns_light != 3'b100 && ew_light != 3'b100) begin
        fails++; $display("FAIL safety: ns=%b ew=%b phase=%0d", ns_light, ew_light, phase);
      end
    end
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 started = 1;
    model_reset();
    asserts++;
    if (obs !== exp_out()) begin fails++; $display("FAIL reset_async: got %b want %b", obs, exp_out()); end
    repeat (3) @(posedge clk);
    #1 asserts++;
    if (obs !== exp_out()) begin fails++; $display("FAIL reset_hold: got %b want %b", obs, exp_out()); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      asserts++;
      if (ns_light !== (i == 0 ? 3'b100 : 3'b010)) begin
        fails++; $display("FAIL first_green tick%0d: got %b want %b", i, ns_light, i == 0 ? 3'b100 : 3'b010);
      end
    end
  endtask
  task automatic test_free_run();
    for (int i = 0; i < 60; i++) begin
      tick(0, 0);
      asserts++;
      if (obs !== exp_out()) begin fails++; $display("FAIL free_run tick%0d: got %b want %b", i, obs, exp_out()); end
    end
  endtask
  task automatic test_ped();
    bit ok;
    int walks = 0, acks = 0;
    advance_to(EW_GREEN, 2, 0, ok);
    asserts++;
    if (!ok) begin fails++; $display("FAIL ped_reach: got timeout want EW_GREEN"); end
    tick(1, 0);
    for (int i = 0; i < 50; i++) begin
      tick(m_ph == PED_WALK && m_el == 2, 0);
      asserts++;
      if (obs !== exp_out()) begin fails++; $display("FAIL ped tick%0d: got %b want %b", i, obs, exp_out()); end
      walks += int'(ped_walk);
      acks  += int'(ped_ack);
    end
    asserts++;
    if (walks != W || acks != 1) begin fails++; $display("FAIL ped_counts: got walk=%0d ack=%0d want %0d/1", walks, acks, W); end
  endtask
  task automatic test_late_req();
    bit ok;
    advance_to(ALL_RED_2, AR - 1, 0, ok);
    asserts++;
    if (!ok) begin fails++; $display("FAIL late_reach: got timeout want ALL_RED_2"); end
    tick(1, 0);
    asserts++;
    if ({ped_walk, ped_ack} !== 2'b11) begin fails++; $display("FAIL late_walk: got %b want 11", {ped_walk, ped_ack}); end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0);
      asserts++;
      if (obs !== exp_out()) begin fails++; $display("FAIL late tick%0d: got %b want %b", i, obs, exp_out()); end
    end
  endtask
  task automatic test_flash();
    bit ok;
    advance_to(NS_GREEN, 1, 0, ok);
    asserts++;
    if (!ok) begin fails++; $display("FAIL flash_reach: got timeout want NS_GREEN"); end
    for (int i = 0; i < 30; i++) begin
      tick(0, 1);
      asserts++;
      if (obs !== exp_out()) begin fails++; $display("FAIL flash tick%0d: got %b want %b", i, obs, exp_out()); end
    end
    asserts++;
    if (phase !== 3'(FLASH)) begin fails++; $display("FAIL flash_entered: got %0d want %0d", phase, 3'(FLASH)); end
    for (int i = 0; i < AR + 1; i++) begin
      tick(0, 0);
      asserts++;
      if (phase !== (i < AR ? 3'(ALL_RED_2) : 3'(NS_GREEN))) begin
        fails++; $display("FAIL flash_exit tick%0d: got %0d want %0d", i, phase, i < AR ? 3'(ALL_RED_2) : 3'(NS_GREEN));
      end
    end
  endtask
  task automatic test_random();
    bit f = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(39) == 0) f = !f;
      tick($urandom_range(9) == 0, f);
      asserts++;
      if (obs !== exp_out()) begin fails++; $display("FAIL random tick%0d: got %b want %b", i, obs, exp_out()); end
    end
    tick(0, 0);
  endtask
  task automatic test_reset_mid();
    bit ok;
    advance_to(EW_GREEN, 1, 0, ok);
    tick(1, 0);
    advance_to(EW_YELLOW, 1, 0, ok);
    asserts++;
    if (!ok) begin fails++; $display("FAIL rstmid_reach: got timeout want EW_YELLOW"); end
    #3 rst_n = 1'b0;
    #1 model_reset();
    asserts++;
    if (obs !== exp_out()) begin fails++; $display("FAIL rstmid_async: got %b want %b", obs, exp_out()); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      asserts++;
      if (obs !== exp_out() || ped_walk !== 1'b0) begin
        fails++; $display("FAIL rstmid tick%0d: got %b want %b", i, obs, exp_out());
      end
    end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_ped();
    test_late_req();
    test_flash();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
